// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply or restoring divide
// on operand magnitudes, followed by a sign-fix step that writes hi/lo.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_q, neg_d;
  logic             negr_q, negr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_borrow;
  logic [WIDTH-1:0] div_rem;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Operand magnitudes for signed ops
  always_comb begin
    abs_a = (op[0] && opA[WIDTH-1]) ? (WIDTH'(0) - opA) : opA;
    abs_b = (op[0] && opB[WIDTH-1]) ? (WIDTH'(0) - opB) : opB;
  end

  // One multiply step: add multiplicand into upper half when LSB set, then shift right
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring-divide step; the shifted remainder needs WIDTH+1 bits
  always_comb begin
    rem_sh     = acc_q[AW-1:WIDTH-1];
    div_diff   = {1'b0, rem_sh} - {2'b00, opb_q};
    div_borrow = div_diff[WIDTH+1];
    div_rem    = div_borrow ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_next   = {div_rem, acc_q[WIDTH-2:0], ~div_borrow};
  end

  always_comb begin
    prod_fix = neg_q  ? (AW'(0) - acc_q) : acc_q;
    quot_fix = neg_q  ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = negr_q ? (WIDTH'(0) - acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    dvd_d    = dvd_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          is_div_d = op[1];
          acc_d    = {WIDTH'(0), abs_a};
          opb_d    = abs_b;
          dvd_d    = opA;
          neg_d    = op[0] & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          negr_d   = op[0] & opA[WIDTH-1];
          cnt_d    = '0;
          dbz_d    = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (!is_div_q) begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (opb_q == '0) begin
          hi_d  = dvd_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      dvd_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      dvd_q    <= dvd_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  // Reference: 64-bit integer arithmetic, SV division truncates toward zero
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     pv;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ed = 1'b0;
    case (o)
      2'd0: begin pv = ua * ub; eh = pv[63:32]; el = pv[31:0]; end
      2'd1: begin pv = 64'(sa * sb); eh = pv[63:32]; el = pv[31:0]; end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ed = 1'b1;
        end else if (o == 2'd2) begin
          eh = 32'(ua % ub); el = 32'(ua / ub);
        end else begin
          q = sa / sb; r = sa % sb;
          eh = 32'(r); el = 32'(q);
        end
      end
    endcase
  endfunction

  // Issue one op from a point just after an edge; return after the done pulse appears.
  // edges = index k of the edge Ek after which done was seen (E0 = accepting edge).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int glitch, output int edges, output logic busy0, output logic dbz0);
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); opA = $urandom; opB = $urandom;
    busy0 = busy; dbz0 = divByZero; edges = 0;
    while (!done && edges < 200) begin
      if (edges == glitch - 1) begin
        start = 1'b1; opA = $urandom; opB = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, divByZero, hi, lo} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
               busy, done, divByZero, hi, lo);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int e; logic b0, d0;
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, e, b0, d0);
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL multu_busy_after_e0: got %b want 1", b0); end
    checks++; if (e !== 33) begin failures++; $display("FAIL multu_latency: got %0d want 33", e); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      failures++; $display("FAIL multu_result: got %h_%h want fffffffe_00000001", hi, lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int e; logic b0, d0;
    do_op(2'd1, 32'hFFFF_FFFD, 32'd5, -1, e, b0, d0);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      failures++; $display("FAIL mult_neg3x5: got %h_%h want ffffffff_fffffff1", hi, lo); end
    do_op(2'd1, 32'd7, 32'hFFFF_FFFA, -1, e, b0, d0);
    checks++; if (e + 1 !== 34) begin failures++; $display("FAIL b2b_spacing: got %0d want 34", e + 1); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      failures++; $display("FAIL mult_7xneg6: got %h_%h want ffffffff_ffffffd6", hi, lo); end
  endtask

  task automatic test_divide();
    int e; logic b0, d0;
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1, e, b0, d0);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      failures++; $display("FAIL div_neg7by2: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
    do_op(2'd2, 32'd100, 32'd7, -1, e, b0, d0);
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL divu_100by7: got hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
  endtask

  task automatic test_div_zero();
    int e; logic b0, d0;
    do_op(2'd2, 32'h64, 32'd0, -1, e, b0, d0);
    checks++; if (hi !== 32'h64 || lo !== 32'hFFFF_FFFF || divByZero !== 1'b1 || e !== 33) begin
      failures++; $display("FAIL divu_by_zero: got hi=%h lo=%h dbz=%b lat=%0d want 64 ffffffff 1 33",
                           hi, lo, divByZero, e); end
    @(posedge clk); #1;
    checks++; if (divByZero !== 1'b1) begin failures++; $display("FAIL dbz_hold_idle: got %b want 1", divByZero); end
    do_op(2'd2, 32'd9, 32'd3, -1, e, b0, d0);
    checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL dbz_clear_on_start: got %b want 0", d0); end
    checks++; if (hi !== 32'd0 || lo !== 32'd3) begin
      failures++; $display("FAIL divu_9by3: got hi=%0d lo=%0d want 0 3", hi, lo); end
  endtask

  task automatic test_overflow_ignored_start();
    int e; logic b0, d0;
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5, e, b0, d0);
    checks++; if (e !== 33) begin failures++; $display("FAIL ovf_latency: got %0d want 33", e); end
    checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000 || divByZero !== 1'b0) begin
      failures++; $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b want 0 80000000 0", hi, lo, divByZero); end
  endtask

  task automatic test_async_reset();
    int e, seen; logic b0, d0;
    op = 2'd0; opA = 32'd3; opB = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if ({busy, done, divByZero, hi, lo} !== 67'd0) begin
      failures++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo); end
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (done) seen++; end
    @(negedge clk); rst = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL no_done_after_reset: got %0d pulses want 0", seen); end
    do_op(2'd0, 32'd3, 32'd4, -1, e, b0, d0);
    checks++; if (hi !== 32'd0 || lo !== 32'd12 || e !== 33) begin
      failures++; $display("FAIL multu_3x4_post_reset: got hi=%0d lo=%0d lat=%0d want 0 12 33", hi, lo, e); end
  endtask

  task automatic test_random();
    int e, kind; logic b0, d0, ed;
    logic [1:0] o; logic [31:0] a, b, eh, el;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom); a = $urandom; b = $urandom;
      kind = $urandom_range(0, 5);
      if (kind == 0) b = 32'd0;
      else if (kind == 1) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (kind == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind == 3) b = 32'($signed(32'($urandom_range(0, 30))) - 15);
      model(o, a, b, eh, el, ed);
      do_op(o, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 32) : -1, e, b0, d0);
      checks++;
      if (hi !== eh || lo !== el || divByZero !== ed || e !== 33) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d want %h %h %b 33",
                 i, o, a, b, hi, lo, divByZero, e, eh, el, ed);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_divide();
    test_div_zero();
    test_overflow_ignored_start();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
